rv32_instr_encoder: RTL and testbench

- Inverse of the opcode-to-control decode path: takes instruction fields (opcode, rd, rs1, rs2, funct3, funct7, imm) and emits encoded RV32I instruction words.
- Writes each word sequentially into a core's instruction memory over a write handshake.
- Serves as the boot/test program loader for either core of the dual-core system.
- Covers the decoded opcode set: R, I-arith, LW, SW, Branch, JAL, JALR.

---
 rtl/rv32_instr_encoder.sv | 152 +++++++++++++++
 tb/tb_rv32_instr_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_instr_encoder.sv
// RV32I instruction encoder/loader: packs field bundles into instruction words and writes them to imem.
// Optional build macro RV32_ENC_IMM_RANGE_CHECK_EN rejects immediates that do not fit their format.
//
// state | meaning
// IDLE  | waiting for a field bundle; in_ready = !full
// WRITE | imem_we high, addr/data held until imem_ready
module rv32_instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic              err,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IA   = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;

  localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t      state, state_nxt;
  logic [31:0] enc_word;
  logic        enc_ok;
  logic        hs;

  // Upper immediate bits never reach any encoding.
  logic unused_imm;
  assign unused_imm = ^imm[31:21];

`ifdef RV32_ENC_IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               fits_i, fits_b, fits_j;
  assign simm   = $signed(imm);
  assign fits_i = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign fits_b = !imm[0] && (simm >= -32'sd4096) && (simm <= 32'sd4094);
  assign fits_j = !imm[0] && (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
`endif

  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b1;
    case (opcode)
      OP_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IA, OP_LW, OP_JALR: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
`ifdef RV32_ENC_IMM_RANGE_CHECK_EN
        enc_ok = fits_i;
`endif
      end
      OP_S: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
`ifdef RV32_ENC_IMM_RANGE_CHECK_EN
        enc_ok = fits_i;
`endif
      end
      OP_B: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
`ifdef RV32_ENC_IMM_RANGE_CHECK_EN
        enc_ok = fits_b;
`endif
      end
      OP_J: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
`ifdef RV32_ENC_IMM_RANGE_CHECK_EN
        enc_ok = fits_j;
`endif
      end
      default: enc_ok = 1'b0;
    endcase
  end

  assign full = (count == DEPTH_C);
  assign hs   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!clr && hs && enc_ok) state_nxt = WRITE;
      WRITE: if (clr || imem_ready)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    imem_we  = 1'b0;
    case (state)
      IDLE:  in_ready = rst_n && !full;
      WRITE: imem_we  = 1'b1;
      default: ;
    endcase
  end

  // clr wins over a simultaneous handshake or write completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imem_addr  <= BASE_C;
      imem_wdata <= 32'h0;
      count      <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (clr) begin
        imem_addr <= BASE_C;
        count     <= '0;
      end else begin
        case (state)
          IDLE: if (hs) begin
            if (enc_ok) imem_wdata <= enc_word;
            else        err        <= 1'b1;
          end
          WRITE: if (imem_ready) begin
            imem_addr <= imem_addr + 1'b1;
            count     <= count + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv32_instr_encoder.sv
// Directed bench for rv32_instr_encoder: vector table plus stall/clear/reset/full sequences.
module tb_rv32_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n, clr, imem_ready;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic        v0, rdy0, we0, err0, full0;
  logic [9:0]  addr0;
  logic [31:0] wdata0;
  logic [10:0] cnt0;

  logic        v1, rdy1, we1, err1, full1;
  logic [9:0]  addr1;
  logic [31:0] wdata1;
  logic [10:0] cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int exp_addr = 0;

  always #5 clk = ~clk;

  rv32_instr_encoder #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v0), .in_ready(rdy0),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wdata0), .imem_ready(imem_ready), .err(err0),
    .full(full0), .count(cnt0));

  rv32_instr_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) u1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(v1), .in_ready(rdy1),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm(imm), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wdata1), .imem_ready(imem_ready), .err(err1),
    .full(full1), .count(cnt1));

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic        exp_err;
    logic [31:0] exp_word;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2;
    funct3 = v.f3; funct7 = v.f7; imm = v.imm;
  endtask

  initial begin
    int nwr;
    logic [31:0] addi_big_word;
    logic        addi_big_err;
`ifdef RV32_ENC_IMM_RANGE_CHECK_EN
    addi_big_err = 1'b1; addi_big_word = 32'h0;
`else
    addi_big_err = 1'b0; addi_big_word = 32'h00000093;
`endif
    //          op          rd   rs1  rs2  f3    f7           imm            err   word
    vecs[0]  = '{7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0000000, 32'd0,        1'b0, 32'h002081B3}; // add x3,x1,x2
    vecs[1]  = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'b0000000, 32'd5,        1'b0, 32'h00500093}; // addi x1,x0,5
    vecs[2]  = '{7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'b0000000, 32'd8,        1'b0, 32'h0020A423}; // sw x2,8(x1)
    vecs[3]  = '{7'b0000011, 5'd5, 5'd2, 5'd0, 3'd2, 7'b0000000, 32'hFFFFFFFC, 1'b0, 32'hFFC12283}; // lw x5,-4(x2)
    vecs[4]  = '{7'b1100111, 5'd0, 5'd1, 5'd0, 3'd0, 7'b0000000, 32'd0,        1'b0, 32'h00008067}; // jalr x0,0(x1)
    vecs[5]  = '{7'b0110011, 5'd5, 5'd6, 5'd7, 3'd0, 7'b0100000, 32'd0,        1'b0, 32'h407302B3}; // sub x5,x6,x7
    vecs[6]  = '{7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'b0000000, 32'd0,        1'b1, 32'h0};        // lui: rejected
    vecs[7]  = '{7'b1100011, 5'd0, 5'd5, 5'd0, 3'd1, 7'b0000000, 32'hFFFFFFFC, 1'b0, 32'hFE029EE3}; // bne x5,x0,-4
    vecs[8]  = '{7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'b0000000, 32'hFFFFFFF8, 1'b0, 32'hFF9FF06F}; // jal x0,-8
    vecs[9]  = '{7'b0000000, 5'd0, 5'd0, 5'd0, 3'd0, 7'b0000000, 32'd0,        1'b1, 32'h0};        // zero opcode
    vecs[10] = '{7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'b0000000, 32'd4096,     addi_big_err, addi_big_word};
    vecs[11] = '{7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'b0000000, 32'd16,       1'b0, 32'h010000EF}; // jal x1,16

    rst_n = 1'b0; clr = 1'b0; imem_ready = 1'b1; v0 = 1'b0; v1 = 1'b0;
    drive(vecs[0]);
    step(); step();
    chk("rst_in_ready", {31'd0, rdy0}, 32'd0);
    chk("rst_we", {31'd0, we0}, 32'd0);
    chk("rst_addr", {22'd0, addr0}, 32'd0);
    chk("rst_wdata", wdata0, 32'd0);
    chk("rst_err", {31'd0, err0}, 32'd0);
    chk("rst_full", {31'd0, full0}, 32'd0);
    chk("rst_count", {21'd0, cnt0}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, rdy0}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      v0 = 1'b1;
      step();
      v0 = 1'b0;
      if (vecs[i].exp_err) begin
        chk($sformatf("v%0d_err_pulse", i), {31'd0, err0}, 32'd1);
        chk($sformatf("v%0d_no_we", i), {31'd0, we0}, 32'd0);
        step();
        chk($sformatf("v%0d_err_drop", i), {31'd0, err0}, 32'd0);
        chk($sformatf("v%0d_cnt_hold", i), {21'd0, cnt0}, exp_cnt);
      end else begin
        chk($sformatf("v%0d_we", i), {31'd0, we0}, 32'd1);
        chk($sformatf("v%0d_wdata", i), wdata0, vecs[i].exp_word);
        chk($sformatf("v%0d_addr", i), {22'd0, addr0}, exp_addr);
        step();
        exp_cnt++; exp_addr++;
        chk($sformatf("v%0d_count", i), {21'd0, cnt0}, exp_cnt);
        chk($sformatf("v%0d_we_drop", i), {31'd0, we0}, 32'd0);
      end
    end

    // BEQ stalled three cycles, then JAL
    imem_ready = 1'b0;
    drive('{7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0, 32'h0});
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("stall_we", {31'd0, we0}, 32'd1);
      chk("stall_wdata", wdata0, 32'h00208463);
      chk("stall_addr", {22'd0, addr0}, exp_addr);
      chk("stall_in_ready", {31'd0, rdy0}, 32'd0);
      step();
    end
    imem_ready = 1'b1;
    chk("stall_end_we", {31'd0, we0}, 32'd1);
    step();
    exp_cnt++; exp_addr++;
    chk("stall_count", {21'd0, cnt0}, exp_cnt);
    drive(vecs[11]);
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("jal_wdata", wdata0, 32'h010000EF);
    chk("jal_addr", {22'd0, addr0}, exp_addr);
    step();
    exp_cnt++; exp_addr++;

    // clr during stalled write
    imem_ready = 1'b0;
    drive(vecs[0]);
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    chk("clr_pre_we", {31'd0, we0}, 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_cnt = 0; exp_addr = 0;
    chk("clr_we", {31'd0, we0}, 32'd0);
    chk("clr_addr", {22'd0, addr0}, 32'd0);
    chk("clr_count", {21'd0, cnt0}, 32'd0);
    chk("clr_in_ready", {31'd0, rdy0}, 32'd1);
    imem_ready = 1'b1;

    // clr beats a simultaneous handshake
    v0 = 1'b1; clr = 1'b1;
    step();
    v0 = 1'b0; clr = 1'b0;
    chk("clr_prio_we", {31'd0, we0}, 32'd0);
    chk("clr_prio_err", {31'd0, err0}, 32'd0);

    // one completed write, then reset mid-write
    drive(vecs[1]);
    v0 = 1'b1;
    step();
    v0 = 1'b0;
    step();
    chk("pre_rst_count", {21'd0, cnt0}, 32'd1);
    imem_ready = 1'b0;
    drive(vecs[6]);
    v0 = 1'b1;
    step();
    drive(vecs[0]);
    step();
    v0 = 1'b0;
    chk("pre_rst_we", {31'd0, we0}, 32'd1);
    rst_n = 1'b0;
    step();
    chk("rstw_we", {31'd0, we0}, 32'd0);
    chk("rstw_addr", {22'd0, addr0}, 32'd0);
    chk("rstw_count", {21'd0, cnt0}, 32'd0);
    chk("rstw_err", {31'd0, err0}, 32'd0);
    chk("rstw_wdata", wdata0, 32'd0);
    rst_n = 1'b1;
    imem_ready = 1'b1;
    step();
    chk("rstw_in_ready", {31'd0, rdy0}, 32'd1);

    // DEPTH = 4: bundle held valid continuously
    drive(vecs[0]);
    nwr = 0;
    v1 = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      if (we1) begin
        chk("full_seq_addr", {22'd0, addr1}, nwr);
        nwr++;
      end
    end
    v1 = 1'b0;
    chk("full_writes", nwr, 32'd4);
    chk("full_flag", {31'd0, full1}, 32'd1);
    chk("full_in_ready", {31'd0, rdy1}, 32'd0);
    chk("full_count", {21'd0, cnt1}, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
